// File: rtl/music_seq_address_pkg.sv
// Shared definitions for the music sequencer address generator.
//  - state_e : playback state encoding (S_IDLE, S_PLAY, S_PAUSE, S_DONE)
//  - ADDR_W_DEF / DIV_W_DEF : default widths of the note address and the
//    tempo prescaler.
package music_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DIV_W_DEF  = 22;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/music_seq_address_tempo_prescaler.sv
// Tempo prescaler: counts clock cycles within one note.
// Ports:
//  clk, rst      clock, synchronous active-high reset
//  en_i          advance the counter this cycle
//  clr_i         force the counter to zero (wins over en_i)
//  tempo_div_i   terminal value (cycles per note minus 1)
//  tc_o          counter has reached or passed tempo_div_i
// On a terminal-count cycle with en_i the counter returns to zero.
module tempo_prescaler #(
    parameter int DIV_W = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] tempo_div_i,
    output logic             tc_o
);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    // ">=" rather than "==" so that lowering tempo_div below the current
    // count ends the note immediately instead of counting all the way round.
    assign tc_o = (count_q >= tempo_div_i);

    // Next count: clear, wrap on terminal count, increment, or hold.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            if (tc_o) begin
                count_d = '0;
            end else begin
                count_d = count_q + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/music_seq_address.sv
// Music sequencer address generator: steps the note-ROM address at a
// programmable tempo with start/pause/stop control, an inclusive end
// address, optional looping and a one-cycle note strobe.
// Ports:
//  clk, rst      clock, synchronous active-high reset
//  start         begin (IDLE/DONE) or resume (PAUSE); 1-cycle request
//  pause         freeze playback (PLAY only); 1-cycle request
//  stop          abort to IDLE with address 0; 1-cycle request
//  loop_en       wrap to 0 after end_addr instead of finishing
//  end_addr      last note address played
//  tempo_div     clock cycles per note minus 1
//  adrs          current note-ROM address (registered)
//  note_strobe   pulse when adrs presents a new note (registered)
//  playing/done  state decodes
// Request priority: rst > stop > start > pause.
module music_seq_address
    import music_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DIV_W  = DIV_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [DIV_W-1:0]  tempo_div,
    output logic [ADDR_W-1:0] adrs,
    output logic              note_strobe,
    output logic              playing,
    output logic              done
);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] adrs_q;
    logic [ADDR_W-1:0] adrs_d;
    logic              strobe_q;
    logic              strobe_d;
    logic              presc_en_s;
    logic              presc_clr_s;
    logic              presc_tc_s;

    tempo_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk         (clk),
        .rst         (rst),
        .en_i        (presc_en_s),
        .clr_i       (presc_clr_s),
        .tempo_div_i (tempo_div),
        .tc_o        (presc_tc_s)
    );

    // Next-state, address and strobe logic.
    always_comb begin
        state_d     = state_q;
        adrs_d      = adrs_q;
        strobe_d    = 1'b0;
        presc_en_s  = 1'b0;
        presc_clr_s = 1'b0;
        if (stop) begin
            state_d     = S_IDLE;
            adrs_d      = '0;
            presc_clr_s = 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d     = S_PLAY;
                        adrs_d      = '0;
                        presc_clr_s = 1'b1;
                        strobe_d    = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_PAUSE: begin
                    // Prescaler stays frozen through the resume cycle.
                    if (start) begin
                        state_d = S_PLAY;
                    end else begin
                        state_d = S_PAUSE;
                    end
                end
                S_PLAY: begin
                    // A simultaneous start outranks pause; start itself is a
                    // no-op while playing, so playback simply continues.
                    if (pause && !start) begin
                        state_d = S_PAUSE;
                    end else begin
                        presc_en_s = 1'b1;
                        if (presc_tc_s) begin
                            if (adrs_q != end_addr) begin
                                adrs_d   = adrs_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                                strobe_d = 1'b1;
                            end else if (loop_en) begin
                                adrs_d   = '0;
                                strobe_d = 1'b1;
                            end else begin
                                state_d = S_DONE;
                            end
                        end else begin
                            adrs_d = adrs_q;
                        end
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    adrs_d      = '0;
                    presc_clr_s = 1'b1;
                end
            endcase
        end
    end

    // State, address and strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            adrs_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            adrs_q   <= adrs_d;
            strobe_q <= strobe_d;
        end
    end

    assign adrs        = adrs_q;
    assign note_strobe = strobe_q;
    assign playing     = (state_q == S_PLAY);
    assign done        = (state_q == S_DONE);

endmodule
